// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD raster timing path: panel timing sets,
// RGB888 colour constants and the controller state encoding.
package lcd_pkg;

  // Controller states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  // One axis of a panel timing set; total includes the front porch
  typedef struct packed {
    logic [10:0] sync;
    logic [10:0] back;
    logic [10:0] disp;
    logic [10:0] total;
  } lcd_axis_t;

  typedef struct packed {
    lcd_axis_t h;
    lcd_axis_t v;
  } lcd_timing_t;

  localparam lcd_timing_t LCD_480X272 = '{
    h: '{sync: 11'd41,  back: 11'd2,   disp: 11'd480,  total: 11'd525},
    v: '{sync: 11'd10,  back: 11'd2,   disp: 11'd272,  total: 11'd286}};
  localparam lcd_timing_t LCD_800X480 = '{
    h: '{sync: 11'd128, back: 11'd88,  disp: 11'd800,  total: 11'd1056},
    v: '{sync: 11'd2,   back: 11'd33,  disp: 11'd480,  total: 11'd525}};
  localparam lcd_timing_t LCD_1024X600 = '{
    h: '{sync: 11'd20,  back: 11'd140, disp: 11'd1024, total: 11'd1344},
    v: '{sync: 11'd3,   back: 11'd20,  disp: 11'd600,  total: 11'd635}};

  // RGB888 colours
  localparam logic [23:0] WHITE = 24'hFF_FF_FF;
  localparam logic [23:0] BLACK = 24'h00_00_00;
  localparam logic [23:0] RED   = 24'hFF_00_00;
  localparam logic [23:0] GREEN = 24'h00_FF_00;
  localparam logic [23:0] BLUE  = 24'h00_00_FF;

endpackage

// File: rtl/lcd_scan_counter.sv
// Horizontal/vertical raster counter pair. clear forces both to zero and
// wins over hold; hold freezes them. frame_last_o flags the final pixel
// clock of a frame.
module lcd_scan_counter #(
  parameter int H_TOTAL = 525,
  parameter int V_TOTAL = 286
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        hold_i,
  output logic [10:0] h_cnt_o,
  output logic [10:0] v_cnt_o,
  output logic        frame_last_o
);

  localparam logic [10:0] H_MAX = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_MAX = 11'(V_TOTAL - 1);

  logic [10:0] h_q, h_d, v_q, v_d;
  logic        h_last;

  assign h_last       = (h_q == H_MAX);
  assign frame_last_o = h_last && (v_q == V_MAX);
  assign h_cnt_o      = h_q;
  assign v_cnt_o      = v_q;

  // Next count: h wraps each line, v advances on h wrap and wraps per frame
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (clear_i) begin
      h_d = '0;
      v_d = '0;
    end else if (!hold_i) begin
      if (h_last) begin
        h_d = '0;
        v_d = (v_q == V_MAX) ? '0 : v_q + 11'd1;
      end else begin
        h_d = h_q + 11'd1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

endmodule

// File: rtl/lcd_timing_ctrl.sv
// Raster timing controller for a parallel RGB panel. Coordinates are issued
// one cycle ahead of lcd_de so a registered pixel generator lines up with the
// data-enable window. Stopping always finishes the current frame.
module lcd_timing_ctrl
  import lcd_pkg::*;
#(
  parameter int H_SYNC  = 41,
  parameter int H_BACK  = 2,
  parameter int H_DISP  = 480,
  parameter int H_TOTAL = 525,
  parameter int V_SYNC  = 10,
  parameter int V_BACK  = 2,
  parameter int V_DISP  = 272,
  parameter int V_TOTAL = 286
) (
  input  logic        lcd_pclk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [23:0] pixel_data,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic [10:0] h_disp,
  output logic [10:0] v_disp,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_de,
  output logic [23:0] lcd_rgb,
  output logic        lcd_bl,
  output logic        frame_start
);

  // Window edges; request window leads the active window by one clock
  localparam logic [10:0] HS_END = 11'(H_SYNC);
  localparam logic [10:0] VS_END = 11'(V_SYNC);
  localparam logic [10:0] HA_BEG = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] HA_END = 11'(H_SYNC + H_BACK + H_DISP);
  localparam logic [10:0] HR_BEG = 11'(H_SYNC + H_BACK - 1);
  localparam logic [10:0] HR_END = 11'(H_SYNC + H_BACK + H_DISP - 2);
  localparam logic [10:0] VA_BEG = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] VA_END = 11'(V_SYNC + V_BACK + V_DISP);

  logic [1:0]  state_q, state_d;
  logic [10:0] h_cnt, v_cnt;
  logic        frame_last;
  logic        active, h_act, v_act, req;

  assign active = (state_q != ST_IDLE);

  lcd_scan_counter #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_scan (
    .clk_i        (lcd_pclk),
    .rst_ni       (rst_n),
    .clear_i      (!active),
    .hold_i       (1'b0),
    .h_cnt_o      (h_cnt),
    .v_cnt_o      (v_cnt),
    .frame_last_o (frame_last)
  );

  // Run/stop sequencing; a re-request in STOP beats the frame-end exit
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (en) state_d = ST_RUN;
      ST_RUN:  if (!en) state_d = ST_STOP;
      ST_STOP: begin
        if (en)              state_d = ST_RUN;
        else if (frame_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Sync, data-enable and coordinate decodes
  always_comb begin
    h_act       = (h_cnt >= HA_BEG) && (h_cnt < HA_END);
    v_act       = (v_cnt >= VA_BEG) && (v_cnt < VA_END);
    req         = active && v_act && (h_cnt >= HR_BEG) && (h_cnt <= HR_END);
    lcd_hs      = !(active && (h_cnt < HS_END));
    lcd_vs      = !(active && (v_cnt < VS_END));
    lcd_de      = active && h_act && v_act;
    lcd_bl      = active;
    frame_start = active && (h_cnt == '0) && (v_cnt == '0);
    pixel_xpos  = req ? h_cnt - HR_BEG : '0;
    pixel_ypos  = req ? v_cnt - VA_BEG : '0;
    lcd_rgb     = lcd_de ? pixel_data : 24'h0;
  end

  assign h_disp = 11'(H_DISP);
  assign v_disp = 11'(V_DISP);

endmodule
